acq_sample_sequencer: RTL

Capture-and-replay controller for the 1-bit I/Q acquisition datapath. On `start` it stores one capture window of 1-bit I/Q samples (bit 1 of each 8-bit ADC byte, 4 MHz) into an on-chip buffer. It then replays that window once per Doppler bin to the downstream acquisition correlator. It sits between the front-end sample stream and the correlator/NCO block and owns the Doppler-bin scheduling.

---
 rtl/gnss_acq_pkg.sv | 43 ++++
 rtl/acq_sample_ram.sv | 43 ++++
 rtl/acq_sample_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gnss_acq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnss_acq_pkg
// Description : Shared types and default constants for the 1-bit I/Q
//               acquisition path: sequencer state encoding, the 1-bit I/Q
//               sample type, the replay beat type and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gnss_acq_pkg;

    localparam int ACQ_SAMPLES_PER_MS = 4000;  // 4 MHz front-end sample rate
    localparam int ACQ_CAPTURE_MS     = 1;     // default capture window
    localparam int ACQ_NUM_BINS       = 41;    // default Doppler bin count

    // Sequencer states, explicitly encoded at 3 bits.
    typedef enum logic [2:0] {
        ACQ_IDLE    = 3'd0,
        ACQ_CAPTURE = 3'd1,
        ACQ_SETUP   = 3'd2,
        ACQ_REPLAY  = 3'd3,
        ACQ_FINISH  = 3'd4
    } acq_seq_state_t;

    // One 1-bit I/Q sample as stored in the capture buffer.
    typedef struct packed {
        logic i;
        logic q;
    } iq1_t;

    // One replay beat held in the output skid buffer.
    typedef struct packed {
        iq1_t iq;
        logic last;
    } acq_beat_t;

    // Counter width for a range of n values; never returns zero so that
    // degenerate single-entry configurations still get a legal vector.
    function automatic int acq_addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acq_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : acq_sample_ram
// Description : Simple dual-port capture buffer, DEPTH x 2 bits. One write
//               port, one registered read port (1-cycle latency). The array
//               and read register carry no reset.
// Ports       : clk                  - clock
//               i_wr_en/i_wr_addr/i_wr_data - write port
//               i_rd_en/i_rd_addr    - read request
//               o_rd_data            - read data, valid the cycle after i_rd_en
// Revision    : 1.0 - initial release
// ============================================================================
module acq_sample_ram
    import gnss_acq_pkg::*;
#(
    parameter  int DEPTH = ACQ_SAMPLES_PER_MS * ACQ_CAPTURE_MS,
    localparam int AW    = acq_addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  iq1_t          i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output iq1_t          o_rd_data
);

    iq1_t mem_q [DEPTH];
    iq1_t rd_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/acq_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_sample_sequencer
// Description : Capture-and-replay controller for the 1-bit I/Q acquisition
//               datapath. Captures one window of samples on start, then
//               replays it once per Doppler bin to the correlator through a
//               2-entry skid buffer, sequencing the bin index.
// Ports       : clk, rst (async, active low)
//               start, abort        - control
//               in_valid/in_i/in_q  - front-end sample stream
//               out_valid/out_ready/out_i/out_q/out_last - replay stream
//               out_bin             - current Doppler bin
//               bin_start           - pulse: load NCO / clear accumulators
//               busy, done          - status
// Revision    : 1.0 - initial release
// ============================================================================
module acq_sample_sequencer
    import gnss_acq_pkg::*;
#(
    parameter  int SAMPLES_PER_MS = ACQ_SAMPLES_PER_MS,
    parameter  int CAPTURE_MS     = ACQ_CAPTURE_MS,
    parameter  int NUM_BINS       = ACQ_NUM_BINS,
    localparam int DEPTH          = SAMPLES_PER_MS * CAPTURE_MS,
    localparam int AW             = acq_addr_width(DEPTH),
    localparam int BW             = acq_addr_width(NUM_BINS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          in_i,
    input  logic          in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_i,
    output logic          out_q,
    output logic          out_last,
    output logic [BW-1:0] out_bin,
    output logic          bin_start,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [BW-1:0] c_last_bin  = BW'(NUM_BINS - 1);

    acq_seq_state_t  state_q,     state_d;
    logic [AW-1:0]   wr_addr_q,   wr_addr_d;
    logic [AW-1:0]   rd_addr_q,   rd_addr_d;
    logic            rd_done_q,   rd_done_d;     // all reads of this pass issued
    logic [BW-1:0]   bin_q,       bin_d;
    logic            pend_q,      pend_d;        // a RAM read returns this cycle
    logic            pend_last_q, pend_last_d;   // ...and it is index DEPTH-1
    acq_beat_t       skid_q [2];
    acq_beat_t       skid_d [2];
    logic            skid_wptr_q, skid_wptr_d;
    logic            skid_rptr_q, skid_rptr_d;
    logic [1:0]      skid_cnt_q,  skid_cnt_d;

    logic            w_we;
    logic            w_rd_en;
    logic            w_pop;
    logic            w_push;
    logic [2:0]      w_occ;
    iq1_t            w_wr_data;
    iq1_t            w_rd_data;
    acq_beat_t       w_head;

    assign w_wr_data = {in_i, in_q};
    assign w_head    = skid_q[skid_rptr_q];
    assign w_push    = pend_q;
    assign w_pop     = out_valid & out_ready;
    assign w_we      = (state_q == ACQ_CAPTURE) & in_valid & ~abort;

    // Occupancy the buffer will have once the in-flight read lands, after
    // this cycle's pop. A new read is only issued if it will still fit, so
    // back-to-back reads sustain one beat per cycle when out_ready is high.
    assign w_occ   = {1'b0, skid_cnt_q} + {2'b00, pend_q} - {2'b00, w_pop};
    assign w_rd_en = (state_q == ACQ_REPLAY) & ~rd_done_q & (w_occ < 3'd2) & ~abort;

    acq_sample_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_we),
        .i_wr_addr (wr_addr_q),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (rd_addr_q),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_done_d   = rd_done_q;
        bin_d       = bin_q;
        pend_d      = w_rd_en;
        pend_last_d = w_rd_en & (rd_addr_q == c_last_addr);
        skid_d      = skid_q;
        skid_wptr_d = skid_wptr_q;
        skid_rptr_d = skid_rptr_q;
        skid_cnt_d  = skid_cnt_q + {1'b0, w_push} - {1'b0, w_pop};

        if (w_push) begin
            skid_d[skid_wptr_q] = {w_rd_data, pend_last_q};
            skid_wptr_d         = ~skid_wptr_q;
        end
        if (w_pop) begin
            skid_rptr_d = ~skid_rptr_q;
        end

        // Read address stops at the last entry instead of wrapping.
        if (w_rd_en) begin
            if (rd_addr_q == c_last_addr) begin
                rd_done_d = 1'b1;
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end

        case (state_q)
            ACQ_IDLE: begin
                if (start) begin
                    state_d   = ACQ_CAPTURE;
                    wr_addr_d = '0;
                    bin_d     = '0;
                end
            end
            ACQ_CAPTURE: begin
                if (w_we) begin
                    if (wr_addr_q == c_last_addr) begin
                        state_d = ACQ_SETUP;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            ACQ_SETUP: begin
                rd_addr_d = '0;
                rd_done_d = 1'b0;
                state_d   = ACQ_REPLAY;
            end
            ACQ_REPLAY: begin
                if (w_pop && w_head.last) begin
                    if (bin_q == c_last_bin) begin
                        state_d = ACQ_FINISH;
                    end else begin
                        bin_d   = bin_q + 1'b1;
                        state_d = ACQ_SETUP;
                    end
                end
            end
            ACQ_FINISH: begin
                state_d = ACQ_IDLE;
            end
            default: begin
                state_d = ACQ_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start, and
        // discards any buffered or in-flight replay data.
        if (abort) begin
            state_d     = ACQ_IDLE;
            pend_d      = 1'b0;
            pend_last_d = 1'b0;
            skid_cnt_d  = 2'd0;
            skid_wptr_d = 1'b0;
            skid_rptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACQ_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            bin_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
            skid_wptr_q <= 1'b0;
            skid_rptr_q <= 1'b0;
            skid_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_done_q   <= rd_done_d;
            bin_q       <= bin_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            skid_q      <= skid_d;
            skid_wptr_q <= skid_wptr_d;
            skid_rptr_q <= skid_rptr_d;
            skid_cnt_q  <= skid_cnt_d;
        end
    end

    // Data outputs are forced low whenever no beat is presented so a flushed
    // buffer never exposes stale samples.
    assign out_valid = (skid_cnt_q != 2'd0);
    assign out_i     = out_valid & w_head.iq.i;
    assign out_q     = out_valid & w_head.iq.q;
    assign out_last  = out_valid & w_head.last;
    assign out_bin   = bin_q;
    assign bin_start = (state_q == ACQ_SETUP);
    assign done      = (state_q == ACQ_FINISH);
    assign busy      = (state_q != ACQ_IDLE);

endmodule
`default_nettype wire
